// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART packet controller.
//   state_t      - controller FSM encodings
//   ERR_*        - cause codes reported on err_code alongside pkt_err
//   DEFAULT_SYNC - default frame start marker
//   len_in_range - helper: LEN byte acceptable for a given buffer depth
package uart_pkg;

  typedef enum logic [2:0] {
    ST_RECOVER = 3'd0,
    ST_HUNT    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FRAME   = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  function automatic logic len_in_range(input logic [7:0] b, input int max_len);
    return (b != 8'd0) && (int'(b) <= max_len);
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// uart_pkt_buf: payload store for one packet. MAX_LEN x 8 register array with
// a write index (filled while the frame arrives) and a read index (walked
// while the packet drains).
//   clk, rst_n        - clock, synchronous active-low reset
//   wr_clr            - restart write index at 0 (new frame)
//   wr_en, wr_data    - store wr_data at wr_idx and advance
//   rd_clr            - restart read index at 0 (start of drain)
//   rd_adv            - advance read index (byte accepted downstream)
//   wr_idx, rd_idx    - current indices (8 bit, LEN is at most 255)
//   rd_data           - byte at rd_idx
module uart_pkt_buf
  import uart_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_clr,
  input  logic       rd_adv,
  output logic [7:0] wr_idx,
  output logic [7:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx <= 8'd0;
      rd_idx <= 8'd0;
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= 8'd0;
    end else begin
      if (wr_clr) begin
        wr_idx <= 8'd0;
      end else if (wr_en) begin
        mem[wr_idx[AW-1:0]] <= wr_data;
        wr_idx              <= wr_idx + 8'd1;
      end
      if (rd_clr) begin
        rd_idx <= 8'd0;
      end else if (rd_adv) begin
        rd_idx <= rd_idx + 8'd1;
      end
    end
  end

  assign rd_data = mem[rd_idx[AW-1:0]];

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: sequences an 8-bit UART receiver and assembles its
// bytes into frames SYNC, LEN, payload[LEN], CSUM where
// (LEN + sum(payload) + CSUM) mod 256 must be 0. Good payloads are released
// on a byte stream with a last marker.
//   clk, rst_n            - receiver clock, synchronous active-low reset
//   en                    - block enable; low forces RECOVER
//   rx_en                 - receiver enable (low only in RECOVER)
//   rx_data/valid/err     - byte from receiver, one-cycle valid, framing error
//   m_data/valid/last     - payload stream out
//   m_ready               - downstream accept
//   pkt_ok, pkt_err       - one-cycle registered outcome pulses
//   err_code              - cause of the latest pkt_err (held between pulses)
// Optional macro UART_PKT_TIMEOUT_EN: inter-byte timeout of TIMEOUT cycles in
// LEN/PAYLOAD/CSUM reports ERR_TIMEOUT and resyncs the receiver.
//
// Stream handshake: a byte transfers on a cycle where m_valid and m_ready are
// both high; while m_valid is high and m_ready low, m_data and m_last hold.
module uart_rx_packet_ctrl
  import uart_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC,
  parameter logic [15:0] TIMEOUT   = 16'd4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rx_en,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [2:0] err_code
);

  state_t     state_q, state_d;
  logic       rec_cnt_q;
  logic [7:0] len_q, csum_q, csum_d;
  logic       len_load, wr_en, wr_clr, rd_clr, rd_adv;
  logic       ok_set, err_set;
  logic [2:0] err_val;
  logic [7:0] wr_idx, rd_idx, rd_data;
  logic [7:0] csum_sum;
  logic       to_hit;

  uart_pkt_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_clr  (wr_clr),
    .wr_en   (wr_en),
    .wr_data (rx_data),
    .rd_clr  (rd_clr),
    .rd_adv  (rd_adv),
    .wr_idx  (wr_idx),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign rx_en    = (state_q != ST_RECOVER);
  assign m_valid  = (state_q == ST_DRAIN);
  assign m_data   = m_valid ? rd_data : 8'd0;
  assign m_last   = m_valid && (rd_idx == len_q - 8'd1);
  assign csum_sum = csum_q + rx_data;

`ifdef UART_PKT_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        in_frame;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  // Fires on the cycle the count would reach TIMEOUT; a byte or error on the
  // same cycle takes priority.
  assign to_hit = in_frame && !rx_valid && !rx_err && (to_cnt_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n || rx_valid || !in_frame) to_cnt_q <= 16'd0;
    else                                 to_cnt_q <= to_cnt_q + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    csum_d   = csum_q;
    len_load = 1'b0;
    wr_en    = 1'b0;
    wr_clr   = 1'b0;
    rd_clr   = 1'b0;
    rd_adv   = 1'b0;
    ok_set   = 1'b0;
    err_set  = 1'b0;
    err_val  = ERR_NONE;
    if (!en) begin
      // Disable drops whatever is in flight silently.
      state_d = ST_RECOVER;
    end else begin
      case (state_q)
        ST_RECOVER: if (rec_cnt_q) state_d = ST_HUNT;
        ST_HUNT: begin
          if (rx_err) begin
            err_set = 1'b1;
            err_val = ERR_FRAME;
          end else if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_err) begin
            err_set = 1'b1;
            err_val = ERR_FRAME;
            state_d = ST_HUNT;
          end else if (rx_valid) begin
            if (len_in_range(rx_data, MAX_LEN)) begin
              len_load = 1'b1;
              csum_d   = rx_data;
              wr_clr   = 1'b1;
              state_d  = ST_PAYLOAD;
            end else begin
              err_set = 1'b1;
              err_val = ERR_LEN;
              state_d = ST_HUNT;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_err) begin
            err_set = 1'b1;
            err_val = ERR_FRAME;
            state_d = ST_HUNT;
          end else if (rx_valid) begin
            wr_en  = 1'b1;
            csum_d = csum_sum;
            if (wr_idx == len_q - 8'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_err) begin
            err_set = 1'b1;
            err_val = ERR_FRAME;
            state_d = ST_HUNT;
          end else if (rx_valid) begin
            if (csum_sum == 8'd0) begin
              ok_set  = 1'b1;
              rd_clr  = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              err_set = 1'b1;
              err_val = ERR_CSUM;
              state_d = ST_HUNT;
            end
          end
        end
        ST_DRAIN: begin
          // Anything arriving now has nowhere to go; the drain is unaffected.
          if (rx_valid || rx_err) begin
            err_set = 1'b1;
            err_val = ERR_OVERRUN;
          end
          if (m_ready) begin
            rd_adv = 1'b1;
            if (m_last) state_d = ST_HUNT;
          end
        end
        default: state_d = ST_RECOVER;
      endcase
      if (to_hit) begin
        err_set = 1'b1;
        err_val = ERR_TIMEOUT;
        state_d = ST_RECOVER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RECOVER;
      rec_cnt_q <= 1'b0;
      len_q     <= 8'd0;
      csum_q    <= 8'd0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      // Second RECOVER cycle with en high releases the receiver.
      rec_cnt_q <= (state_q == ST_RECOVER) && en;
      if (len_load) len_q <= rx_data;
      csum_q  <= csum_d;
      pkt_ok  <= ok_set;
      pkt_err <= err_set;
      if (err_set) err_code <= err_val;
    end
  end

endmodule
